// File: rtl/mdu_pkg.sv
// Shared encodings, FSM state and latched-op context for the HI/LO multiply/divide unit.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'b000;
   localparam logic [2:0] MDU_MULTU = 3'b001;
   localparam logic [2:0] MDU_DIV   = 3'b010;
   localparam logic [2:0] MDU_DIVU  = 3'b011;
   localparam logic [2:0] MDU_MTHI  = 3'b100;
   localparam logic [2:0] MDU_MTLO  = 3'b101;

   localparam int MDU_ITER = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state_e;

   // What FIX needs to know about the op that was issued.
   typedef struct packed {
      logic is_div;
      logic sgn;
      logic sa;
      logic sb;
      logic bz;
   } mdu_ctx_t;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module mdu_divstep #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic         dbit,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic         qbit
);

   logic [W:0] trial;
   logic [W:0] diff;

   assign trial    = {rem, dbit};
   assign diff     = trial - {1'b0, divisor};
   // Borrow out of the W+1 bit subtract means the divisor did not fit.
   assign qbit     = ~diff[W];
   assign rem_next = qbit ? diff[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int DATASIZE = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [2:0]          op,
   input  logic                flush,
   input  logic [DATASIZE-1:0] srca,
   input  logic [DATASIZE-1:0] srcb,
   output logic [DATASIZE-1:0] hi,
   output logic [DATASIZE-1:0] lo,
   output logic                busy,
   output logic                done
);

   localparam int MSB = DATASIZE - 1;

   mdu_state_e          state;
   mdu_ctx_t            ctx;
   logic [5:0]          cnt;
   logic [DATASIZE-1:0] acc;
   logic [DATASIZE-1:0] mq;
   logic [DATASIZE-1:0] opb;
   logic [DATASIZE-1:0] orig_a;

   logic                is_md, is_mt, sgn_in;
   logic [DATASIZE-1:0] a_mag, b_mag;

   assign is_md  = ~op[2];
   assign is_mt  = (op == MDU_MTHI) || (op == MDU_MTLO);
   assign sgn_in = ~op[0];
   assign a_mag  = (sgn_in && srca[MSB]) ? -srca : srca;
   assign b_mag  = (sgn_in && srcb[MSB]) ? -srcb : srcb;

   // acc:mq is the 64-bit product shifter for multiply, remainder:dividend/quotient for divide.
   logic [DATASIZE:0]   mul_sum;
   logic [DATASIZE-1:0] div_rem;
   logic                div_q;

   assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);

   mdu_divstep #(.W(DATASIZE)) u_divstep (
      .rem      (acc),
      .dbit     (mq[MSB]),
      .divisor  (opb),
      .rem_next (div_rem),
      .qbit     (div_q)
   );

   logic [2*DATASIZE-1:0] prod_f;
   logic [DATASIZE-1:0]   quo_f, rem_f, res_hi, res_lo;

   always_comb begin
      prod_f = (ctx.sgn && (ctx.sa ^ ctx.sb)) ? -{acc, mq} : {acc, mq};
      quo_f  = (ctx.sgn && (ctx.sa ^ ctx.sb)) ? -mq : mq;
      rem_f  = (ctx.sgn && ctx.sa) ? -acc : acc;
      res_hi = prod_f[2*DATASIZE-1:DATASIZE];
      res_lo = prod_f[DATASIZE-1:0];
      if (ctx.is_div) begin
         res_hi = rem_f;
         res_lo = quo_f;
         if (ctx.bz) begin
            res_hi = orig_a;
            res_lo = '1;
         end
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         ctx    <= '0;
         cnt    <= '0;
         acc    <= '0;
         mq     <= '0;
         opb    <= '0;
         orig_a <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  if (is_mt) begin
                     if (op == MDU_MTLO) lo <= srca;
                     else                hi <= srca;
                  end else if (is_md) begin
                     ctx.is_div <= op[1];
                     ctx.sgn    <= sgn_in;
                     ctx.sa     <= sgn_in & srca[MSB];
                     ctx.sb     <= sgn_in & srcb[MSB];
                     ctx.bz     <= (srcb == '0);
                     acc        <= '0;
                     mq         <= op[1] ? a_mag : b_mag;
                     opb        <= op[1] ? b_mag : a_mag;
                     orig_a     <= srca;
                     cnt        <= '0;
                     state      <= RUN;
                  end
               end
            end
            RUN: begin
               if (flush) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  if (ctx.is_div) begin
                     acc <= div_rem;
                     mq  <= {mq[MSB-1:0], div_q};
                  end else begin
                     acc <= mul_sum[DATASIZE:1];
                     mq  <= {mul_sum[0], mq[MSB:1]};
                  end
                  if (cnt == 6'(MDU_ITER - 1)) begin
                     cnt   <= '0;
                     state <= FIX;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            FIX: begin
               state <= IDLE;
               if (!flush) begin
                  hi   <= res_hi;
                  lo   <= res_lo;
                  done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: vector table for mul/div results plus hand sequences for timing corners.
module tb_mdu_hilo;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic        flush;
   logic [31:0] srca, srcb;
   logic [31:0] hi, lo;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   mdu_hilo #(.DATASIZE(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .flush (flush),
      .srca  (srca),
      .srcb  (srcb),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t vecs [14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one mul/div and follow it through to done; optionally poke a DIVU while busy.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string nm, input bit inj);
      logic [31:0] h0, l0;
      int n;
      bit held, early;
      h0 = hi; l0 = lo;
      start = 1'b1; op = o; srca = a; srcb = b;
      tick();
      start = 1'b0; op = 3'b110; srca = 32'h0; srcb = 32'h0;
      n = 0; held = 1'b1; early = 1'b0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (hi !== h0 || lo !== l0) held = 1'b0;
         if (done !== 1'b0) early = 1'b1;
         if (inj && n == 5) begin
            start = 1'b1; op = MDU_DIVU; srca = 32'd100; srcb = 32'd7;
         end else if (inj && n == 6) begin
            start = 1'b0; op = 3'b110; srca = 32'h0; srcb = 32'h0;
         end
         tick();
      end
      chk({nm, "_busy_cycles"}, 64'(n), 64'd33);
      chk({nm, "_hilo_held"}, 64'(held), 64'd1);
      chk({nm, "_no_early_done"}, 64'(early), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd1);
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
      tick();
      chk({nm, "_done_clr"}, 64'(done), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      bit seen;
      vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[4]  = '{MDU_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
      vecs[5]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[6]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7]  = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[8]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[9]  = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[10] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[11] = '{MDU_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
      vecs[12] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
      vecs[13] = '{MDU_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};

      reset = 1'b0; start = 1'b0; op = 3'b110; flush = 1'b0; srca = '0; srcb = '0;
      #1;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("post_rst_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 14; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el,
                $sformatf("vec%0d", i), 1'b0);

      // Back-to-back MTHI/MTLO, one per cycle.
      start = 1'b1; op = MDU_MTHI; srca = 32'h11111111;
      tick();
      chk("mthi_hi", 64'(hi), 64'h11111111);
      chk("mthi_busy", 64'(busy), 64'd0);
      op = MDU_MTLO;
      tick();
      chk("mtlo_lo", 64'(lo), 64'h11111111);
      chk("mtlo_hi_keep", 64'(hi), 64'h11111111);
      chk("mtlo_done", 64'(done), 64'd0);
      start = 1'b0; op = 3'b110;

      // Flush MULT 3x4 mid-run.
      start = 1'b1; op = MDU_MULT; srca = 32'd3; srcb = 32'd4;
      tick();
      start = 1'b0; op = 3'b110;
      repeat (9) tick();
      chk("flush_busy_before", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_idle", 64'(busy), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
         tick();
      end
      chk("flush_no_done", 64'(seen), 64'd0);
      chk("flush_hi", 64'(hi), 64'h11111111);
      chk("flush_lo", 64'(lo), 64'h11111111);
      start = 1'b1; op = MDU_MTLO; srca = 32'h0000ABCD;
      tick();
      start = 1'b0; op = 3'b110;
      chk("mtlo_after_flush", 64'(lo), 64'h0000ABCD);

      // Flush in IDLE blocks a simultaneous MTHI.
      start = 1'b1; op = MDU_MTHI; srca = 32'hDEADBEEF; flush = 1'b1;
      tick();
      start = 1'b0; op = 3'b110; flush = 1'b0;
      chk("idle_flush_hi", 64'(hi), 64'h11111111);
      chk("idle_flush_busy", 64'(busy), 64'd0);

      // DIVU poked during a MULTU run is dropped.
      run_op(MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, "inj", 1'b1);

      // start held high: the second issue lands exactly at E34.
      start = 1'b1; op = MDU_MULTU; srca = 32'd3; srcb = 32'd5;
      tick();
      repeat (33) tick();
      chk("b2b_busy_e33", 64'(busy), 64'd0);
      chk("b2b_done_e33", 64'(done), 64'd1);
      chk("b2b_lo_e33", 64'(lo), 64'd15);
      tick();
      start = 1'b0; op = 3'b110;
      chk("b2b_busy_e34", 64'(busy), 64'd1);
      chk("b2b_done_e34", 64'(done), 64'd0);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      chk("b2b_second_cycles", 64'(n), 64'd33);
      chk("b2b_second_lo", 64'(lo), 64'd15);
      chk("b2b_second_hi", 64'(hi), 64'd0);

      // Async reset in the middle of a DIV.
      start = 1'b1; op = MDU_DIV; srca = 32'hFFFFFFF9; srcb = 32'd2;
      tick();
      start = 1'b0; op = 3'b110;
      repeat (19) tick();
      chk("areset_busy_before", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("areset_hi", 64'(hi), 64'd0);
      chk("areset_lo", 64'(lo), 64'd0);
      chk("areset_busy", 64'(busy), 64'd0);
      chk("areset_done", 64'(done), 64'd0);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      chk("areset_stays_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
